// File: rtl/mbus_arbiter_if.sv
// mbus interface: read address/data and write address/data/response channels.
// The master modport is the side that issues addresses; the slave modport
// is the side that accepts them and returns responses.
interface mbus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_valid;
    logic                    r_ready;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    b_resp;
    logic                    b_valid;
    logic                    b_ready;

    modport master (
        output ar_addr, ar_valid, r_ready,
        output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
        input  ar_ready, r_data, r_valid, aw_ready, b_resp, b_valid
    );

    modport slave (
        input  ar_addr, ar_valid, r_ready,
        input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
        output ar_ready, r_data, r_valid, aw_ready, b_resp, b_valid
    );
endinterface

// File: rtl/mbus_arbiter.sv
// Two-master mbus arbiter. Each address channel (AR and AW+W) has its own
// round-robin grant with a hold lock, and an order FIFO that remembers which
// master issued each accepted address so R and B responses are routed back.
// All paths are combinational; only pointer, lock and FIFO are registered.

// One arbitrated channel: request mux toward the bus, response demux back.
module mbus_arbiter_chan #(
    parameter int REQ_W   = 32,
    parameter int RSP_W   = 32,
    parameter int OT_BITS = 3
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic [1:0]       req_valid_i,
    input  logic [REQ_W-1:0] req_data0_i,
    input  logic [REQ_W-1:0] req_data1_i,
    output logic [1:0]       req_ready_o,
    output logic             bus_valid_o,
    output logic [REQ_W-1:0] bus_data_o,
    input  logic             bus_ready_i,
    input  logic             bus_rsp_valid_i,
    input  logic [RSP_W-1:0] bus_rsp_data_i,
    output logic             bus_rsp_ready_o,
    output logic [1:0]       rsp_valid_o,
    output logic [RSP_W-1:0] rsp_data0_o,
    output logic [RSP_W-1:0] rsp_data1_o,
    input  logic [1:0]       rsp_ready_i,
    output logic             orphan_o
);
    localparam int DEPTH = 1 << OT_BITS;
    localparam logic [OT_BITS:0] DEPTH_CNT = {1'b1, {OT_BITS{1'b0}}};

    logic               ptr_q, ptr_d;
    logic               lock_q, lock_d;
    logic               lock_idx_q, lock_idx_d;
    logic [DEPTH-1:0]   fifo_q;
    logic [OT_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [OT_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [OT_BITS:0]   cnt_q, cnt_d;

    logic empty, full, head;
    logic push, pop;
    logic gnt_valid, gnt_idx;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == DEPTH_CNT);
    assign head  = fifo_q[rd_ptr_q];

    // Grant, request/response muxing and pointer/lock next state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        req_ready_o     = '0;
        bus_valid_o     = 1'b0;
        bus_data_o      = '0;
        bus_rsp_ready_o = 1'b0;
        rsp_valid_o     = '0;
        rsp_data0_o     = '0;
        rsp_data1_o     = '0;
        orphan_o        = 1'b0;
        push            = 1'b0;
        pop             = 1'b0;
        gnt_valid       = 1'b0;
        gnt_idx         = 1'b0;
        ptr_d           = ptr_q;
        lock_d          = lock_q;
        lock_idx_d      = lock_idx_q;

        if (!reset_i) begin
            // Response side: FIFO head names the destination master.
            if (empty) begin
                orphan_o = bus_rsp_valid_i;
            end else begin
                bus_rsp_ready_o   = rsp_ready_i[head];
                rsp_valid_o[head] = bus_rsp_valid_i;
                if (head) rsp_data1_o = bus_rsp_data_i;
                else      rsp_data0_o = bus_rsp_data_i;
                pop = bus_rsp_valid_i && rsp_ready_i[head];
            end

            // Request side: a locked master keeps the bus until accepted.
            if (lock_q) begin
                gnt_idx   = lock_idx_q;
                gnt_valid = req_valid_i[lock_idx_q];
            end else begin
                gnt_idx   = (&req_valid_i) ? ptr_q : req_valid_i[1];
                gnt_valid = |req_valid_i;
            end

            // A pop in the same cycle frees the slot a full FIFO needs.
            if (full && !pop) gnt_valid = 1'b0;

            if (gnt_valid) begin
                bus_valid_o          = 1'b1;
                bus_data_o           = gnt_idx ? req_data1_i : req_data0_i;
                req_ready_o[gnt_idx] = bus_ready_i;
                push                 = bus_ready_i;
                lock_idx_d           = gnt_idx;
            end
            lock_d = gnt_valid && !bus_ready_i;
            if (push) ptr_d = ~gnt_idx;
        end
    end

    // FIFO pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + OT_BITS'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + OT_BITS'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (OT_BITS+1)'(1);
            2'b01:   cnt_d = cnt_q - (OT_BITS+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset_i) begin
            ptr_q      <= 1'b0;
            lock_q     <= 1'b0;
            lock_idx_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Order FIFO storage: records the granted master on each handshake.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; entries are only read
        // when the count says they were written.
        if (push) fifo_q[wr_ptr_q] <= gnt_idx;
    end
endmodule

// Top: one channel instance for reads, one for writes, plus the orphan flag.
module mbus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int OT_BITS    = 3
) (
    input  logic           clk,
    input  logic           reset,
    mbus_arbiter_if.slave  m0,
    mbus_arbiter_if.slave  m1,
    mbus_arbiter_if.master mbus,
    output logic           err_orphan
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int AW_W   = ADDR_WIDTH + DATA_WIDTH + STRB_W;

    logic [1:0]            ar_ready, r_valid;
    logic [DATA_WIDTH-1:0] r_data0, r_data1;
    logic [1:0]            aw_ready, b_valid;
    logic                  b_resp0, b_resp1;
    logic [AW_W-1:0]       aw_bus;
    logic                  ar_orphan, b_orphan;
    logic                  err_q, err_d;

    mbus_arbiter_chan #(
        .REQ_W(ADDR_WIDTH), .RSP_W(DATA_WIDTH), .OT_BITS(OT_BITS)
    ) u_rd (
        .clk            (clk),
        .reset_i        (reset),
        .req_valid_i    ({m1.ar_valid, m0.ar_valid}),
        .req_data0_i    (m0.ar_addr),
        .req_data1_i    (m1.ar_addr),
        .req_ready_o    (ar_ready),
        .bus_valid_o    (mbus.ar_valid),
        .bus_data_o     (mbus.ar_addr),
        .bus_ready_i    (mbus.ar_ready),
        .bus_rsp_valid_i(mbus.r_valid),
        .bus_rsp_data_i (mbus.r_data),
        .bus_rsp_ready_o(mbus.r_ready),
        .rsp_valid_o    (r_valid),
        .rsp_data0_o    (r_data0),
        .rsp_data1_o    (r_data1),
        .rsp_ready_i    ({m1.r_ready, m0.r_ready}),
        .orphan_o       (ar_orphan)
    );

    mbus_arbiter_chan #(
        .REQ_W(AW_W), .RSP_W(1), .OT_BITS(OT_BITS)
    ) u_wr (
        .clk            (clk),
        .reset_i        (reset),
        .req_valid_i    ({m1.aw_valid, m0.aw_valid}),
        .req_data0_i    ({m0.aw_addr, m0.w_data, m0.w_strb}),
        .req_data1_i    ({m1.aw_addr, m1.w_data, m1.w_strb}),
        .req_ready_o    (aw_ready),
        .bus_valid_o    (mbus.aw_valid),
        .bus_data_o     (aw_bus),
        .bus_ready_i    (mbus.aw_ready),
        .bus_rsp_valid_i(mbus.b_valid),
        .bus_rsp_data_i (mbus.b_resp),
        .bus_rsp_ready_o(mbus.b_ready),
        .rsp_valid_o    (b_valid),
        .rsp_data0_o    (b_resp0),
        .rsp_data1_o    (b_resp1),
        .rsp_ready_i    ({m1.b_ready, m0.b_ready}),
        .orphan_o       (b_orphan)
    );

    assign m0.ar_ready = ar_ready[0];
    assign m1.ar_ready = ar_ready[1];
    assign m0.r_valid  = r_valid[0];
    assign m1.r_valid  = r_valid[1];
    assign m0.r_data   = r_data0;
    assign m1.r_data   = r_data1;
    assign m0.aw_ready = aw_ready[0];
    assign m1.aw_ready = aw_ready[1];
    assign m0.b_valid  = b_valid[0];
    assign m1.b_valid  = b_valid[1];
    assign m0.b_resp   = b_resp0;
    assign m1.b_resp   = b_resp1;

    // The W beat rides with its address, so it shares the AW valid.
    assign mbus.aw_addr = aw_bus[AW_W-1 -: ADDR_WIDTH];
    assign mbus.w_data  = aw_bus[STRB_W +: DATA_WIDTH];
    assign mbus.w_strb  = aw_bus[STRB_W-1:0];
    assign mbus.w_valid = mbus.aw_valid;

    // Sticky orphan-response flag, next state.
    always_comb begin
        err_d = err_q | ar_orphan | b_orphan;
    end

    // Sticky orphan-response flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign err_orphan = err_q;
endmodule

// File: tb/tb_mbus_arbiter.sv
// Directed bench for mbus_arbiter: grants, round-robin, lock, FIFO full,
// write path, response routing, orphan flag and asynchronous reset.
module tb_mbus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic err_orphan;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mbus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    mbus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
    mbus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    mbus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OT_BITS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0        (m0_if),
        .m1        (m1_if),
        .mbus      (bus_if),
        .err_orphan(err_orphan)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_if.ar_addr = '0; m0_if.ar_valid = 0; m0_if.r_ready = 0;
        m0_if.aw_addr = '0; m0_if.aw_valid = 0; m0_if.w_data = '0;
        m0_if.w_strb = '0; m0_if.w_valid = 0; m0_if.b_ready = 0;
        m1_if.ar_addr = '0; m1_if.ar_valid = 0; m1_if.r_ready = 0;
        m1_if.aw_addr = '0; m1_if.aw_valid = 0; m1_if.w_data = '0;
        m1_if.w_strb = '0; m1_if.w_valid = 0; m1_if.b_ready = 0;
        bus_if.ar_ready = 0; bus_if.r_data = '0; bus_if.r_valid = 0;
        bus_if.aw_ready = 0; bus_if.b_resp = 0; bus_if.b_valid = 0;
    endtask

    task automatic reset_pulse();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    logic [31:0] exp_addr[4] = '{32'h0, 32'h4, 32'h0, 32'h4};
    logic [31:0] rdat[4]     = '{32'hA, 32'hB, 32'hC, 32'hD};

    initial begin
        idle();
        // Reset state, with a live request that must not leak through.
        m0_if.ar_valid = 1; m0_if.ar_addr = 32'h55; bus_if.ar_ready = 1;
        #2;
        check("rst_ar_valid", bus_if.ar_valid, 0);
        check("rst_ar_addr",  bus_if.ar_addr, 0);
        check("rst_m0_ready", m0_if.ar_ready, 0);
        check("rst_err",      err_orphan, 0);
        step();
        reset_pulse();

        // Single read from M0.
        m0_if.ar_valid = 1; m0_if.ar_addr = 32'h100; bus_if.ar_ready = 1;
        #1;
        check("t1_ar_addr",  bus_if.ar_addr, 32'h100);
        check("t1_ar_valid", bus_if.ar_valid, 1);
        check("t1_m0_ready", m0_if.ar_ready, 1);
        check("t1_m1_ready", m1_if.ar_ready, 0);
        step();
        m0_if.ar_valid = 0;
        bus_if.r_valid = 1; bus_if.r_data = 32'hDEADBEEF; m0_if.r_ready = 1;
        #1;
        check("t1_r_data",  m0_if.r_data, 32'hDEADBEEF);
        check("t1_r_v0",    m0_if.r_valid, 1);
        check("t1_r_v1",    m1_if.r_valid, 0);
        check("t1_r_ready", bus_if.r_ready, 1);
        step();
        reset_pulse();

        // Both masters request every cycle: strict alternation from M0.
        m0_if.ar_valid = 1; m0_if.ar_addr = 32'h0;
        m1_if.ar_valid = 1; m1_if.ar_addr = 32'h4;
        bus_if.ar_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_rr_addr", bus_if.ar_addr, exp_addr[i]);
            step();
        end
        m0_if.ar_valid = 0; m1_if.ar_valid = 0;
        m0_if.r_ready = 1; m1_if.r_ready = 1;
        for (int i = 0; i < 4; i++) begin
            bus_if.r_valid = 1; bus_if.r_data = rdat[i];
            #1;
            check("t2_r_v0", m0_if.r_valid, (i % 2 == 0));
            check("t2_r_v1", m1_if.r_valid, (i % 2 == 1));
            check("t2_r_data", (i % 2 == 0) ? m0_if.r_data : m1_if.r_data, rdat[i]);
            step();
        end
        reset_pulse();

        // Lock: M1 held off by the slave while M0 also requests.
        m1_if.ar_valid = 1; m1_if.ar_addr = 32'h20; bus_if.ar_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_hold_addr", bus_if.ar_addr, 32'h20);
            check("t3_hold_m0",   m0_if.ar_ready, 0);
            step();
            m0_if.ar_valid = 1; m0_if.ar_addr = 32'h30;
        end
        bus_if.ar_ready = 1;
        #1;
        check("t3_hs_addr", bus_if.ar_addr, 32'h20);
        check("t3_hs_m1",   m1_if.ar_ready, 1);
        check("t3_hs_m0",   m0_if.ar_ready, 0);
        step();
        m1_if.ar_valid = 0;
        #1;
        check("t3_next_addr", bus_if.ar_addr, 32'h30);
        check("t3_next_m0",   m0_if.ar_ready, 1);
        step();
        reset_pulse();

        // FIFO full: eight outstanding reads, ninth waits for a pop.
        m0_if.ar_valid = 1; bus_if.ar_ready = 1;
        for (int i = 0; i < 8; i++) begin
            m0_if.ar_addr = 32'h1000 + 32'(i * 4);
            #1;
            check("t4_fill_valid", bus_if.ar_valid, 1);
            step();
        end
        m0_if.ar_addr = 32'h2000;
        #1;
        check("t4_full_valid", bus_if.ar_valid, 0);
        check("t4_full_ready", m0_if.ar_ready, 0);
        bus_if.r_valid = 1; bus_if.r_data = 32'h77; m0_if.r_ready = 1;
        #1;
        check("t4_pop_valid", bus_if.ar_valid, 1);
        check("t4_pop_ready", m0_if.ar_ready, 1);
        check("t4_pop_addr",  bus_if.ar_addr, 32'h2000);
        check("t4_pop_r",     bus_if.r_ready, 1);
        step();
        bus_if.r_valid = 0;
        #1;
        check("t4_still_full", bus_if.ar_valid, 0);
        step();
        reset_pulse();

        // Simultaneous writes, B returned in issue order.
        m0_if.aw_valid = 1; m0_if.aw_addr = 32'h40; m0_if.w_data = 32'h12345678; m0_if.w_strb = 4'hF;
        m1_if.aw_valid = 1; m1_if.aw_addr = 32'h44; m1_if.w_data = 32'hCAFEF00D; m1_if.w_strb = 4'h3;
        bus_if.aw_ready = 1;
        #1;
        check("t5_aw0_addr", bus_if.aw_addr, 32'h40);
        check("t5_aw0_data", bus_if.w_data, 32'h12345678);
        check("t5_aw0_strb", bus_if.w_strb, 4'hF);
        check("t5_aw0_wv",   bus_if.w_valid, 1);
        check("t5_aw0_rdy",  m0_if.aw_ready, 1);
        step();
        m0_if.aw_valid = 0;
        #1;
        check("t5_aw1_addr", bus_if.aw_addr, 32'h44);
        check("t5_aw1_data", bus_if.w_data, 32'hCAFEF00D);
        check("t5_aw1_strb", bus_if.w_strb, 4'h3);
        check("t5_aw1_rdy",  m1_if.aw_ready, 1);
        step();
        m1_if.aw_valid = 0;
        #1;
        check("t5_idle_wv", bus_if.w_valid, 0);
        m0_if.b_ready = 1; m1_if.b_ready = 1;
        bus_if.b_valid = 1; bus_if.b_resp = 0;
        #1;
        check("t5_b0_v0", m0_if.b_valid, 1);
        check("t5_b0_v1", m1_if.b_valid, 0);
        step();
        bus_if.b_resp = 1;
        #1;
        check("t5_b1_v0",   m0_if.b_valid, 0);
        check("t5_b1_v1",   m1_if.b_valid, 1);
        check("t5_b1_resp", m1_if.b_resp, 1);
        step();
        bus_if.b_valid = 0;
        #1;

        // Orphan write response.
        bus_if.b_valid = 1;
        #1;
        check("t6_orph_ready", bus_if.b_ready, 0);
        check("t6_orph_pre",   err_orphan, 0);
        step();
        bus_if.b_valid = 0;
        check("t6_orph_set", err_orphan, 1);
        step();
        check("t6_orph_hold", err_orphan, 1);

        // Three reads outstanding, then reset mid-burst.
        m0_if.ar_valid = 1; m0_if.ar_addr = 32'h300; bus_if.ar_ready = 1;
        step(); step(); step();
        bus_if.r_valid = 1; bus_if.r_data = 32'h99; m0_if.r_ready = 1;
        #1;
        check("t6_pre_rv", m0_if.r_valid, 1);
        reset = 1'b1;
        #1;
        check("t6_rst_arv", bus_if.ar_valid, 0);
        check("t6_rst_rv",  m0_if.r_valid, 0);
        check("t6_rst_rr",  bus_if.r_ready, 0);
        check("t6_rst_err", err_orphan, 0);
        step();
        m0_if.ar_valid = 0;
        reset = 1'b0;
        #1;
        check("t6_empty_rr", bus_if.r_ready, 0);
        check("t6_empty_rv", m0_if.r_valid, 0);
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mbus_arbiter.md
Name: mbus_arbiter

Overview:
- Shares one mbus port between two requesters: M0 is the vector memory queue, M1 is an auxiliary master (scalar/debug DMA).
- Read (AR/R) and write (AW/W/B) channels are arbitrated independently, round-robin.
- Per-channel order FIFOs route each R and B response back to the master that issued the matching address.
- Sits between the Vfu memory queue and the SoC bus.

Parameters:
- ADDR_WIDTH, 32, mbus address width.
- DATA_WIDTH, 32, mbus data width.
- OT_BITS, 3, log2 of the maximum outstanding transactions per channel (default 8).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- mN_ar_addr in ADDR_WIDTH; mN_ar_valid in 1; mN_ar_ready out 1: read-address channel of master N (N=0,1).
- mN_r_data out DATA_WIDTH; mN_r_valid out 1; mN_r_ready in 1: read-data channel of master N.
- mN_aw_addr in ADDR_WIDTH; mN_aw_valid in 1; mN_aw_ready out 1: write-address channel of master N.
- mN_w_data in DATA_WIDTH; mN_w_strb in DATA_WIDTH/8: write data, qualified by mN_aw_valid.
- mN_b_resp out 1; mN_b_valid out 1; mN_b_ready in 1: write-response channel of master N.
- mbus_ar_addr out ADDR_WIDTH; mbus_ar_valid out 1; mbus_ar_ready in 1: downstream read address.
- mbus_r_data in DATA_WIDTH; mbus_r_valid in 1; mbus_r_ready out 1: downstream read data.
- mbus_aw_addr out ADDR_WIDTH; mbus_aw_valid out 1; mbus_aw_ready in 1: downstream write address.
- mbus_w_data out DATA_WIDTH; mbus_w_strb out DATA_WIDTH/8; mbus_w_valid out 1: downstream write data (no ready).
- mbus_b_resp in 1; mbus_b_valid in 1; mbus_b_ready out 1: downstream write response.
- err_orphan out 1: sticky; response arrived with no outstanding entry.

Behaviour:
- Reset (async, any cycle incl. mid-transfer): order FIFOs emptied; RR pointers point to M0; locks cleared; err_orphan=0.
- In reset, all valid/ready outputs are 0 and address/data/strb outputs are 0.
- AR arbitration, combinational grant:
  - If the lock is set, the locked master keeps the grant.
  - Otherwise the requesting master is granted; if both request, the master the pointer names is granted.
  - No grant while the read FIFO is full (mbus_ar_valid=0, mN_ar_ready=0).
- AR muxing: mbus_ar_addr/valid come from the granted master; only the granted mN_ar_ready follows mbus_ar_ready.
- AR lock: set when mbus_ar_valid=1 and mbus_ar_ready=0, so addr/valid stay stable until accepted; cleared on handshake.
- AR handshake: push the granted index into the read FIFO; the pointer moves to the other master.
- R routing: FIFO head selects the destination. mbus_r_ready = m[head]_r_ready. m[head]_r_valid = mbus_r_valid; the other master's r_valid = 0.
- R pop: on mbus_r_valid & mbus_r_ready, the FIFO pops.
- AW/W: the same arbitration, lock and FIFO scheme as AR, applied to AW. mbus_w_data/strb come from the granted master; mbus_w_valid = mbus_aw_valid (W beat travels with AW). B is routed and popped like R.
- Simultaneous push and pop on a full FIFO: allowed; count is unchanged.
- Response with empty FIFO: mbus_r_ready/mbus_b_ready = 0 and err_orphan is set.
- Latency: zero added cycles on every channel (pure mux path). One registered state per channel: pointer, lock, FIFO.
- Each FIFO: depth 2^OT_BITS, 1 bit wide; count is OT_BITS+1 bits; pointers wrap modulo depth.

Test Plan:
- Only M0 issues AR 0x100; slave ready immediately; R 0xDEADBEEF one cycle later -> mbus_ar_addr=0x100 the same cycle, m0_r_data=0xDEADBEEF, m1_r_valid stays 0.
- Both masters assert AR every cycle (M0 0x0, M1 0x4) with slave always ready -> bus sees 0x0,0x4,0x0,0x4; returned R beats A,B,C,D land on M0,M1,M0,M1.
- M1 AR 0x20 held with mbus_ar_ready=0 for 3 cycles while M0 raises a request -> address stays 0x20 and stays granted to M1; M0 is granted the cycle after the handshake.
- OT_BITS=3: issue 8 ARs with no R -> 9th AR gives mbus_ar_valid=0. Return one R beat -> the 9th AR is issued in the same cycle as the pop.
- M0 write 0x40/0x12345678/strb 0xF and M1 write 0x44 at once, B returned in order -> first B to M0, second to M1; mbus_w_valid equals mbus_aw_valid each cycle.
- mbus_b_valid with no outstanding write -> err_orphan=1 the next cycle and holds; assert reset mid-burst with 3 reads outstanding -> all valids 0, FIFO empty, err_orphan=0 immediately.
